// File: rtl/segre_mem_stage.sv
// segre_mem_stage: memory pipeline stage with a data-memory request FSM and WB register.
package segre_pkg;
  localparam int WORD_SIZE = 32;
  localparam int ADDR_SIZE = 32;
  localparam int REG_SIZE  = 5;
  typedef enum logic [1:0] {BYTE, HALF, WORD} memop_data_type_e;
endpackage

module segre_mem_stage
  import segre_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic [WORD_SIZE-1:0] alu_res_i,
  input  logic                 rf_we_i,
  input  logic [REG_SIZE-1:0]  rf_waddr_i,
  input  logic [WORD_SIZE-1:0] rf_st_data_i,
  input  memop_data_type_e     memop_type_i,
  input  logic                 memop_rd_i,
  input  logic                 memop_wr_i,
  input  logic                 memop_sign_ext_i,
  input  logic                 valid_mem_i,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [ADDR_SIZE-1:0] dmem_addr_o,
  output logic [3:0]           dmem_be_o,
  output logic [WORD_SIZE-1:0] dmem_wdata_o,
  input  logic                 dmem_gnt_i,
  input  logic                 dmem_rvalid_i,
  input  logic [WORD_SIZE-1:0] dmem_rdata_i,
  output logic                 rf_we_o,
  output logic [REG_SIZE-1:0]  rf_waddr_o,
  output logic [WORD_SIZE-1:0] rf_wdata_o,
  output logic                 valid_wb_o,
  input  logic                 block_mem_i,
  input  logic                 inject_nops_i,
  output logic                 mem_busy_o,
  output logic                 misaligned_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  state_e state, state_nx;
  logic [WORD_SIZE-1:0] alu_q, st_q, shifted, ld_data;
  logic [REG_SIZE-1:0] waddr_q;
  memop_data_type_e type_q;
  logic we_q, rd_q, wr_q, sext_q, valid_q;
  logic mem_op, mis, issue, gnt_done, complete, inject, capture;
  logic [1:0] off;
  always_comb begin
    off = alu_q[1:0];
    mem_op = valid_q && (rd_q || wr_q);
    mis = mem_op && ((type_q == HALF && off[0]) || (type_q == WORD && off != 2'b00));
    issue = state == IDLE && mem_op && !mis && !block_mem_i;
    dmem_req_o = issue || state == REQ;
    gnt_done = dmem_req_o && dmem_gnt_i;
    // loads finish on rvalid, stores on gnt, ALU and misaligned ops immediately
    complete = state == WAIT ? dmem_rvalid_i :
               gnt_done ? wr_q : (state == IDLE && valid_q && (!mem_op || mis));
    mem_busy_o = mem_op && !complete;
    misaligned_o = mis;
    state_nx = state == WAIT ? (dmem_rvalid_i ? IDLE : WAIT) :
               gnt_done ? (wr_q ? IDLE : WAIT) : (dmem_req_o ? REQ : IDLE);
    dmem_addr_o = {alu_q[ADDR_SIZE-1:2], 2'b00};
    dmem_we_o = wr_q;
    dmem_be_o = !mem_op ? 4'b0000 :
                type_q == BYTE ? 4'b0001 << off :
                type_q == HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    dmem_wdata_o = type_q == BYTE ? {4{st_q[7:0]}} :
                   type_q == HALF ? {2{st_q[15:0]}} : st_q;
    shifted = dmem_rdata_i >> {off, 3'b000};
    ld_data = type_q == BYTE ? {{24{sext_q && shifted[7]}}, shifted[7:0]} :
              type_q == HALF ? {{16{sext_q && shifted[15]}}, shifted[15:0]} : shifted;
    // a bubble may only replace an op whose access has not been issued
    inject = inject_nops_i && state == IDLE && !dmem_req_o;
    capture = !mem_busy_o && !block_mem_i;
  end
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state <= IDLE;
      {valid_q, we_q, rd_q, wr_q, sext_q} <= '0;
      alu_q <= '0;
      st_q <= '0;
      waddr_q <= '0;
      type_q <= BYTE;
      valid_wb_o <= 1'b0;
      rf_we_o <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else begin
      state <= state_nx;
      if (inject || (!capture && complete)) begin
        {valid_q, we_q, rd_q, wr_q} <= '0;
      end else if (capture) begin
        valid_q <= valid_mem_i;
        we_q <= rf_we_i;
        rd_q <= memop_rd_i;
        wr_q <= memop_wr_i;
        sext_q <= memop_sign_ext_i;
        alu_q <= alu_res_i;
        st_q <= rf_st_data_i;
        waddr_q <= rf_waddr_i;
        type_q <= memop_type_i;
      end
      valid_wb_o <= complete;
      rf_we_o <= complete && we_q && !wr_q && !mis;
      if (complete) begin
        rf_waddr_o <= waddr_q;
        rf_wdata_o <= (rd_q && !wr_q) ? ld_data : alu_q;
      end
    end
  end
endmodule

// File: tb/tb_segre_mem_stage.sv
// tb_segre_mem_stage: directed stimulus with a write-back scoreboard for segre_mem_stage.
module tb_segre_mem_stage;
  import segre_pkg::*;
  logic clk = 1'b0, rsn = 1'b0;
  logic [31:0] alu_res = '0, st_data = '0, rdata = '0;
  logic rf_we_in = 1'b0, rd = 1'b0, wr = 1'b0, sext = 1'b0, valid = 1'b0;
  logic [4:0] waddr_in = '0;
  memop_data_type_e mtype = WORD;
  logic gnt = 1'b0, rvalid = 1'b0, block = 1'b0, inject = 1'b0;
  logic req, dwe, wb_we, valid_wb, busy, mis;
  logic [31:0] daddr, dwdata, wb_data;
  logic [3:0] be;
  logic [4:0] wb_addr;
  typedef struct {logic we; logic [4:0] waddr; logic [31:0] wdata;} wb_t;
  wb_t q[$];
  wb_t e;
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  segre_mem_stage dut (
    .clk_i(clk), .rsn_i(rsn), .alu_res_i(alu_res), .rf_we_i(rf_we_in), .rf_waddr_i(waddr_in),
    .rf_st_data_i(st_data), .memop_type_i(mtype), .memop_rd_i(rd), .memop_wr_i(wr),
    .memop_sign_ext_i(sext), .valid_mem_i(valid), .dmem_req_o(req), .dmem_we_o(dwe),
    .dmem_addr_o(daddr), .dmem_be_o(be), .dmem_wdata_o(dwdata), .dmem_gnt_i(gnt),
    .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata), .rf_we_o(wb_we), .rf_waddr_o(wb_addr),
    .rf_wdata_o(wb_data), .valid_wb_o(valid_wb), .block_mem_i(block), .inject_nops_i(inject),
    .mem_busy_o(busy), .misaligned_o(mis)
  );

  task automatic chk(string n, logic [31:0] a, logic [31:0] x);
    total++;
    if (a === x) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, x);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic op(logic [31:0] a, logic w, logic [4:0] wa, logic [31:0] sd,
                    memop_data_type_e t, logic r, logic s, logic sx);
    alu_res = a; rf_we_in = w; waddr_in = wa; st_data = sd; mtype = t;
    rd = r; wr = s; sext = sx; valid = 1'b1;
  endtask

  task automatic idle_in();
    valid = 1'b0; rd = 1'b0; wr = 1'b0; rf_we_in = 1'b0;
  endtask

  task automatic load_test(logic [31:0] a, memop_data_type_e t, logic sx, logic [31:0] rd_word,
                           logic [31:0] x_addr, logic [3:0] x_be, logic [31:0] x_data);
    step();
    op(a, 1'b1, 5'd7, 32'h0, t, 1'b1, 1'b0, sx);
    gnt = 1'b1;
    q.push_back('{1'b1, 5'd7, x_data});
    step();
    idle_in();
    #1;
    chk("ld_req", 32'(req), 32'd1);
    chk("ld_addr", daddr, x_addr);
    chk("ld_be", 32'(be), 32'(x_be));
    chk("ld_we", 32'(dwe), 32'd0);
    chk("ld_busy_req", 32'(busy), 32'd1);
    step();
    gnt = 1'b0;
    #1;
    chk("ld_wait_req", 32'(req), 32'd0);
    chk("ld_wait_busy", 32'(busy), 32'd1);
    rvalid = 1'b1;
    rdata = rd_word;
    #1;
    chk("ld_done_busy", 32'(busy), 32'd0);
    step();
    rvalid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (valid_wb) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL wb_unexpected: got valid_wb_o=1 waddr=%0d expected no retire", wb_addr);
      end else begin
        e = q.pop_front();
        chk("wb_we", 32'(wb_we), 32'(e.we));
        if (e.we) begin
          chk("wb_waddr", 32'(wb_addr), 32'(e.waddr));
          chk("wb_wdata", wb_data, e.wdata);
        end
      end
    end
  end

  initial begin
    repeat (2) step();
    #1;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_dwe", 32'(dwe), 32'd0);
    chk("rst_be", 32'(be), 32'd0);
    chk("rst_valid_wb", 32'(valid_wb), 32'd0);
    chk("rst_rf_we", 32'(wb_we), 32'd0);
    chk("rst_waddr", 32'(wb_addr), 32'd0);
    chk("rst_wdata", wb_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mis", 32'(mis), 32'd0);
    rsn = 1'b1;
    // ALU ops, including back-to-back
    step();
    op(32'h1234, 1'b1, 5'd5, 32'h0, WORD, 1'b0, 1'b0, 1'b0);
    q.push_back('{1'b1, 5'd5, 32'h1234});
    step();
    op(32'hDEADBEEF, 1'b1, 5'd31, 32'h0, WORD, 1'b0, 1'b0, 1'b0);
    q.push_back('{1'b1, 5'd31, 32'hDEADBEEF});
    #1;
    chk("alu_busy", 32'(busy), 32'd0);
    chk("alu_req", 32'(req), 32'd0);
    step();
    idle_in();
    step();
    // loads
    load_test(32'h103, BYTE, 1'b1, 32'h80FFFFFF, 32'h100, 4'b1000, 32'hFFFFFF80);
    load_test(32'h103, BYTE, 1'b0, 32'h80FFFFFF, 32'h100, 4'b1000, 32'h00000080);
    load_test(32'h102, HALF, 1'b1, 32'h80011234, 32'h100, 4'b1100, 32'hFFFF8001);
    load_test(32'h100, HALF, 1'b0, 32'h1234F00D, 32'h100, 4'b0011, 32'h0000F00D);
    load_test(32'h104, WORD, 1'b1, 32'hCAFEF00D, 32'h104, 4'b1111, 32'hCAFEF00D);
    // SH with grant withheld for three cycles
    step();
    op(32'h202, 1'b1, 5'd3, 32'h0000ABCD, HALF, 1'b0, 1'b1, 1'b0);
    gnt = 1'b0;
    q.push_back('{1'b0, 5'd3, 32'h0});
    step();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sh_req", 32'(req), 32'd1);
      chk("sh_addr", daddr, 32'h200);
      chk("sh_be", 32'(be), 32'b1100);
      chk("sh_wdata", dwdata, 32'hABCDABCD);
      chk("sh_busy", 32'(busy), 32'd1);
      step();
    end
    gnt = 1'b1;
    #1;
    chk("sh_req_gnt", 32'(req), 32'd1);
    chk("sh_we", 32'(dwe), 32'd1);
    chk("sh_busy_gnt", 32'(busy), 32'd0);
    step();
    gnt = 1'b0;
    #1;
    chk("sh_req_after", 32'(req), 32'd0);
    // SB with immediate grant
    step();
    op(32'h101, 1'b0, 5'd8, 32'h0000005A, BYTE, 1'b0, 1'b1, 1'b0);
    gnt = 1'b1;
    q.push_back('{1'b0, 5'd8, 32'h0});
    step();
    idle_in();
    #1;
    chk("sb_be", 32'(be), 32'b0010);
    chk("sb_wdata", dwdata, 32'h5A5A5A5A);
    chk("sb_busy", 32'(busy), 32'd0);
    step();
    gnt = 1'b0;
    // misaligned LW
    step();
    op(32'h101, 1'b1, 5'd9, 32'h0, WORD, 1'b1, 1'b0, 1'b0);
    gnt = 1'b1;
    q.push_back('{1'b0, 5'd9, 32'h0});
    step();
    idle_in();
    #1;
    chk("mis_req", 32'(req), 32'd0);
    chk("mis_pulse", 32'(mis), 32'd1);
    chk("mis_busy", 32'(busy), 32'd0);
    step();
    gnt = 1'b0;
    #1;
    chk("mis_pulse_end", 32'(mis), 32'd0);
    // reset while waiting for rvalid
    step();
    op(32'h100, 1'b1, 5'd4, 32'h0, WORD, 1'b1, 1'b0, 1'b0);
    gnt = 1'b1;
    step();
    idle_in();
    step();
    gnt = 1'b0;
    #1;
    chk("wait_busy", 32'(busy), 32'd1);
    rsn = 1'b0;
    step();
    rsn = 1'b1;
    rvalid = 1'b1;
    rdata = 32'h77;
    #1;
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_req", 32'(req), 32'd0);
    step();
    rvalid = 1'b0;
    step();
    #1;
    chk("postrst_no_wb", 32'(valid_wb), 32'd0);
    // block holds capture until released
    step();
    op(32'h42, 1'b1, 5'd2, 32'h0, WORD, 1'b0, 1'b0, 1'b0);
    block = 1'b1;
    q.push_back('{1'b1, 5'd2, 32'h42});
    step();
    step();
    #1;
    chk("block_no_wb", 32'(valid_wb), 32'd0);
    block = 1'b0;
    step();
    idle_in();
    step();
    // inject with and without block captures a bubble
    step();
    op(32'h99, 1'b1, 5'd6, 32'h0, WORD, 1'b0, 1'b0, 1'b0);
    block = 1'b1;
    inject = 1'b1;
    step();
    block = 1'b0;
    op(32'h98, 1'b1, 5'd6, 32'h0, WORD, 1'b0, 1'b0, 1'b0);
    step();
    inject = 1'b0;
    idle_in();
    step();
    #1;
    chk("inject_no_wb", 32'(valid_wb), 32'd0);
    repeat (3) step();
    chk("queue_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/segre_mem_stage.md
SEGRE_MEM_STAGE -- requirements
Module: segre_mem_stage

Interface
REQ-001 SHALL use segre_pkg parameters: WORD_SIZE, default 32, data width; ADDR_SIZE, default 32, address width; REG_SIZE, default 5, register index width.
REQ-002 SHALL have one clock and a synchronous, active-low reset: clk_i  in  1  clock, all state on rising edge; rsn_i  in  1  synchronous active-low reset.
REQ-003 SHALL have EX-side inputs: alu_res_i  in  WORD_SIZE  result or effective address; rf_we_i  in  1; rf_waddr_i  in  REG_SIZE; rf_st_data_i  in  WORD_SIZE  store data; memop_type_i  in  memop_data_type_e  BYTE/HALF/WORD; memop_rd_i  in  1; memop_wr_i  in  1; memop_sign_ext_i  in  1; valid_mem_i  in  1  EX holds a valid op.
REQ-004 SHALL have data-memory ports: dmem_req_o  out  1; dmem_we_o  out  1; dmem_addr_o  out  ADDR_SIZE  word-aligned; dmem_be_o  out  4; dmem_wdata_o  out  WORD_SIZE; dmem_gnt_i  in  1; dmem_rvalid_i  in  1; dmem_rdata_i  in  WORD_SIZE.
REQ-005 SHALL have WB-side outputs: rf_we_o  out  1; rf_waddr_o  out  REG_SIZE; rf_wdata_o  out  WORD_SIZE; valid_wb_o  out  1.
REQ-006 SHALL have control ports: block_mem_i  in  1  hold capture register; inject_nops_i  in  1  capture a bubble; mem_busy_o  out  1  stall request to upstream stages; misaligned_o  out  1  one-cycle misalignment pulse.

Function
REQ-007 SHALL capture all EX inputs into an input register on each rising edge where mem_busy_o=0 and block_mem_i=0.
REQ-008 inject_nops_i=1 SHALL capture a bubble (valid=0, rf_we=0, rd=0, wr=0), with priority over block_mem_i and the normal capture of REQ-007; an in-flight access SHALL NOT be cancelled.
REQ-009 block_mem_i=1 SHALL hold the input register and SHALL prevent a new request from IDLE; requests already in REQ or WAIT SHALL complete.
REQ-010 FSM states SHALL be IDLE, REQ, WAIT; reset state IDLE.
REQ-011 IDLE with a valid, aligned captured op and rd or wr set: dmem_req_o=1 combinationally; gnt same cycle -> store completes, load -> WAIT; no gnt -> REQ.
REQ-012 REQ SHALL hold dmem_req_o=1 and keep addr/we/be/wdata stable until dmem_gnt_i=1; then store completes (-> IDLE) and load -> WAIT.
REQ-013 WAIT SHALL keep dmem_req_o=0 and wait for dmem_rvalid_i=1; then the load completes (-> IDLE).
REQ-014 dmem_rvalid_i SHALL be ignored in IDLE and REQ; dmem_gnt_i SHALL be ignored outside IDLE and REQ.
REQ-015 mem_busy_o SHALL equal 1 whenever a captured memop is pending and does not complete in the current cycle; it SHALL be 0 for non-memory ops.
REQ-016 dmem_addr_o SHALL be {alu_res[31:2],2'b00}; dmem_we_o SHALL equal the captured wr.
REQ-017 Byte enables: BYTE -> 4'b0001<<addr[1:0]; HALF -> 4'b0011 if addr[1]=0, else 4'b1100; WORD -> 4'b1111.
REQ-018 Store data SHALL be replicated: byte x4 for BYTE, half x2 for HALF, word unchanged for WORD.
REQ-019 Load data SHALL be rdata shifted right by 8*addr[1:0], masked to the type width, then sign-extended if memop_sign_ext=1, else zero-extended.
REQ-020 Misaligned op (HALF with addr[0]=1, or WORD with addr[1:0]!=0) SHALL issue no request, SHALL pulse misaligned_o for one cycle, and SHALL retire with rf_we_o=0.
REQ-021 The WB output register SHALL load on the completing edge: non-memory op one edge after capture with rf_wdata_o=alu_res; a load on the edge after rvalid with the extracted data; a store with rf_we_o=0.
REQ-022 valid_wb_o SHALL be 1 for exactly one cycle per retired valid op and 0 otherwise, with rf_we_o forced to 0 when valid_wb_o=0.
REQ-023 Minimum load latency SHALL be 2 cycles from capture to valid_wb_o (gnt in first cycle, rvalid in next).

Reset
REQ-024 rsn_i=0 at a rising edge SHALL set state=IDLE, the input register to a bubble, and all of the following to 0: dmem_req_o, dmem_we_o, dmem_be_o, rf_we_o, rf_waddr_o, rf_wdata_o, valid_wb_o, mem_busy_o, misaligned_o.
REQ-025 Reset in REQ or WAIT SHALL drop the pending access; a later dmem_rvalid_i SHALL be ignored and SHALL produce no write-back.

Verification
REQ-026 ALU op alu_res=0x1234, rf_we=1, waddr=5 -> next cycle valid_wb_o=1, rf_wdata_o=0x1234, rf_waddr_o=5, mem_busy_o=0.
REQ-027 LB signed at addr 0x103, gnt immediate, rvalid next cycle with rdata=0x80FFFFFF -> be=0001<<3=1000, addr=0x100, rf_wdata_o=0xFFFFFF80; LBU in the same setup -> 0x00000080.
REQ-028 SH at 0x202 with data 0x0000ABCD, gnt withheld 3 cycles -> req held 4 cycles, be=1100, wdata=0xABCDABCD, mem_busy_o=1 until gnt, rf_we_o=0 at retire.
REQ-029 LW at 0x101 -> no dmem_req_o, misaligned_o pulses once, valid_wb_o=1 with rf_we_o=0.
REQ-030 LW in WAIT with rsn_i=0 for one cycle, then rvalid=1 -> state IDLE, no valid_wb_o; inject_nops_i=1 with block_mem_i=1 -> bubble captured.
